// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, data-enable and start-of-line/frame strobes.
// Latency: outputs describe the position reached on the same clk edge. ce=0 freezes position and clears the strobes.
module vga_timing_gen #(
    parameter int   H_RES         = 1280,
    parameter int   H_FRONT_PORCH = 48,
    parameter int   H_SYNC_PULSE  = 112,
    parameter int   H_BACK_PORCH  = 248,
    parameter int   V_RES         = 1024,
    parameter int   V_FRONT_PORCH = 1,
    parameter int   V_SYNC_PULSE  = 3,
    parameter int   V_BACK_PORCH  = 38,
    parameter logic H_POL         = 1'b1,
    parameter logic V_POL         = 1'b1,
    parameter int   CNT_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [CNT_W-1:0] x_loc,
    output logic [CNT_W-1:0] y_loc,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_RES + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_RES + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_RES);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_RES + H_FRONT_PORCH);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_RES + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_RES + V_FRONT_PORCH);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_RES + V_FRONT_PORCH + V_SYNC_PULSE);

    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;
    logic             h_in_sync;
    logic             v_in_sync;
    logic             de_nxt;

    always_comb begin
        x_nxt = x_loc + CNT_W'(1);
        y_nxt = y_loc;
        if (x_loc == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_loc == V_LAST) ? '0 : y_loc + CNT_W'(1);
        end
    end

    // Decode the position about to be loaded so the syncs line up with x_loc/y_loc.
    // Sync ends never exceed the last count because the back porch is at least one.
    assign h_in_sync = (x_nxt >= H_SYNC_BEG) && (x_nxt < H_SYNC_END);
    assign v_in_sync = (y_nxt >= V_SYNC_BEG) && (y_nxt < V_SYNC_END);
    assign de_nxt    = (x_nxt < H_ACT_END) && (y_nxt < V_ACT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_loc       <= H_LAST;
            y_loc       <= V_LAST;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                x_loc       <= x_nxt;
                y_loc       <= y_nxt;
                h_sync      <= h_in_sync ? H_POL : ~H_POL;
                v_sync      <= v_in_sync ? V_POL : ~V_POL;
                de          <= de_nxt;
                line_start  <= (x_nxt == '0);
                frame_start <= (x_nxt == '0) && (y_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on an 8x6 raster: hand-built vector table, frame-level counts, and random ce/rst against a linear pixel-index model.
module tb_vga_timing_gen;

    localparam int   HR = 4, HFP = 1, HSP = 2, HBP = 1;
    localparam int   VR = 3, VFP = 1, VSP = 1, VBP = 1;
    localparam logic HP = 1'b0, VP = 1'b1;
    localparam int   CW = 4;
    localparam int   HT = HR + HFP + HSP + HBP;
    localparam int   VT = VR + VFP + VSP + VBP;
    localparam int   FR = HT * VT;
    localparam int   OW = 2 * CW + 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce  = 1'b0;
    logic          h_sync, v_sync, de, line_start, frame_start;
    logic [CW-1:0] x_loc, y_loc;
    logic [OW-1:0] act;

    int errors = 0;
    int checks = 0;

    // Model: the raster is one linear pixel index 0..FR-1; x and y fall out of div/mod.
    int pos = FR - 1;
    bit m_ls = 1'b0;
    bit m_fs = 1'b0;

    vga_timing_gen #(
        .H_RES(HR), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
        .V_RES(VR), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
        .H_POL(HP), .V_POL(VP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .h_sync(h_sync), .v_sync(v_sync), .de(de),
        .x_loc(x_loc), .y_loc(y_loc),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    assign act = {x_loc, y_loc, h_sync, v_sync, de, line_start, frame_start};

    typedef struct {
        logic          r;
        logic          c;
        logic [OW-1:0] exp;
    } vec_t;

    function automatic logic [OW-1:0] mk(int x, int y, logic hs, logic vs, logic d, logic ls, logic fs);
        return {CW'(x), CW'(y), hs, vs, d, ls, fs};
    endfunction

    function automatic logic [OW-1:0] model_out(int p, bit ls, bit fs);
        int   x = p % HT;
        int   y = p / HT;
        logic hs = (x >= HR + HFP && x < HR + HFP + HSP) ? HP : ~HP;
        logic vs = (y >= VR + VFP && y < VR + VFP + VSP) ? VP : ~VP;
        logic d  = (x < HR) && (y < VR);
        return mk(x, y, hs, vs, d, ls, fs);
    endfunction

    task automatic model_step(input logic r, input logic c);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (r) begin
            pos = FR - 1;
        end else if (c) begin
            pos  = (pos + 1) % FR;
            m_ls = (pos % HT == 0);
            m_fs = (pos == 0);
        end
    endtask

    task automatic tick(input logic r, input logic c);
        @(negedge clk);
        rst = r;
        ce  = c;
        @(posedge clk);
        #1;
        model_step(r, c);
    endtask

    task automatic check(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (x,y,hs,vs,de,ls,fs)", name, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    vec_t vecs[18];
    int   vs_cnt, de_cnt, ls_cnt;
    int   fs_at[$];

    initial begin
        // Reset, first line, ce holds, then reset mid-frame at (2,1).
        vecs[0]  = '{1'b1, 1'b1, mk(7, 5, 1, 0, 0, 0, 0)};
        vecs[1]  = '{1'b1, 1'b0, mk(7, 5, 1, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 1'b1, mk(0, 0, 1, 0, 1, 1, 1)};
        vecs[3]  = '{1'b0, 1'b0, mk(0, 0, 1, 0, 1, 0, 0)};
        vecs[4]  = '{1'b0, 1'b1, mk(1, 0, 1, 0, 1, 0, 0)};
        vecs[5]  = '{1'b0, 1'b0, mk(1, 0, 1, 0, 1, 0, 0)};
        vecs[6]  = '{1'b0, 1'b1, mk(2, 0, 1, 0, 1, 0, 0)};
        vecs[7]  = '{1'b0, 1'b1, mk(3, 0, 1, 0, 1, 0, 0)};
        vecs[8]  = '{1'b0, 1'b1, mk(4, 0, 1, 0, 0, 0, 0)};
        vecs[9]  = '{1'b0, 1'b1, mk(5, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{1'b0, 1'b1, mk(6, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{1'b0, 1'b1, mk(7, 0, 1, 0, 0, 0, 0)};
        vecs[12] = '{1'b0, 1'b1, mk(0, 1, 1, 0, 1, 1, 0)};
        vecs[13] = '{1'b0, 1'b1, mk(1, 1, 1, 0, 1, 0, 0)};
        vecs[14] = '{1'b0, 1'b1, mk(2, 1, 1, 0, 1, 0, 0)};
        vecs[15] = '{1'b1, 1'b1, mk(7, 5, 1, 0, 0, 0, 0)};
        vecs[16] = '{1'b0, 1'b0, mk(7, 5, 1, 0, 0, 0, 0)};
        vecs[17] = '{1'b0, 1'b1, mk(0, 0, 1, 0, 1, 1, 1)};

        for (int i = 0; i < 18; i++) begin
            tick(vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d", i), act, vecs[i].exp);
        end

        // Two full frames of continuous ce: region widths and frame_start period.
        tick(1'b1, 1'b0);
        vs_cnt = 0;
        de_cnt = 0;
        ls_cnt = 0;
        for (int i = 1; i <= 2 * FR; i++) begin
            tick(1'b0, 1'b1);
            if (i <= FR) begin
                if (v_sync == VP) vs_cnt++;
                if (de) de_cnt++;
                if (line_start) ls_cnt++;
            end
            if (frame_start) fs_at.push_back(i);
        end
        check_int("vsync_clks", vs_cnt, 8);
        check_int("de_clks", de_cnt, 12);
        check_int("line_starts", ls_cnt, 6);
        check_int("frame_starts", fs_at.size(), 2);
        if (fs_at.size() == 2) begin
            check_int("frame_first", fs_at[0], 1);
            check_int("frame_period", fs_at[1] - fs_at[0], 48);
        end

        // Strict ce toggling after reset: position advances every other clk.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, (i % 2) == 0);
            check($sformatf("toggle%0d", i), act, model_out(pos, m_ls, m_fs));
        end

        // Random ce with occasional reset against the pixel-index model.
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
            check($sformatf("rand%0d", i), act, model_out(pos, m_ls, m_fs));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_RES, default 1280, active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT_PORCH, default 48, pixels.
REQ-003 The block SHALL have parameter H_SYNC_PULSE, default 112, pixels.
REQ-004 The block SHALL have parameter H_BACK_PORCH, default 248, pixels; legal range >= 1.
REQ-005 The block SHALL have parameter V_RES, default 1024, active lines per frame.
REQ-006 The block SHALL have parameter V_FRONT_PORCH, default 1, lines.
REQ-007 The block SHALL have parameter V_SYNC_PULSE, default 3, lines.
REQ-008 The block SHALL have parameter V_BACK_PORCH, default 38, lines; legal range >= 1.
REQ-009 The block SHALL have parameter H_POL, default 1, h_sync asserted level (1 = active-high).
REQ-010 The block SHALL have parameter V_POL, default 1, v_sync asserted level.
REQ-011 The block SHALL have parameter CNT_W, default 11, x_loc/y_loc width; must hold H_TOTAL-1 and V_TOTAL-1.
REQ-012 The block SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-013 rst  in  1  synchronous, active-high reset.
REQ-014 ce  in  1  pixel enable; timing advances one pixel per clk with ce=1.
REQ-015 h_sync  out  1  horizontal sync, level per H_POL.
REQ-016 v_sync  out  1  vertical sync, level per V_POL.
REQ-017 de  out  1  data enable, 1 in active region.
REQ-018 x_loc  out  CNT_W  current horizontal position.
REQ-019 y_loc  out  CNT_W  current vertical position.
REQ-020 line_start  out  1  one-clk pulse on entering x_loc=0.
REQ-021 frame_start  out  1  one-clk pulse on entering (x_loc,y_loc)=(0,0).

Function
REQ-022 H_TOTAL = H_RES+H_FRONT_PORCH+H_SYNC_PULSE+H_BACK_PORCH; V_TOTAL likewise for V_*.
REQ-023 All outputs SHALL be registered; h_sync, v_sync, de SHALL decode the same (x_loc,y_loc) presented in that cycle.
REQ-024 On clk with ce=1: x_loc increments; x_loc=H_TOTAL-1 wraps to 0 and increments y_loc; y_loc=V_TOTAL-1 with x wrap wraps to 0.
REQ-025 On clk with ce=0: x_loc, y_loc, h_sync, v_sync, de hold; line_start, frame_start go 0.
REQ-026 Horizontal regions by x_loc: active [0,H_RES-1], front porch, sync [H_RES+H_FRONT_PORCH, H_RES+H_FRONT_PORCH+H_SYNC_PULSE-1], back porch; vertical identical by y_loc.
REQ-027 h_sync = H_POL when x_loc in sync region, else ~H_POL; v_sync likewise by y_loc and V_POL, independent of x_loc.
REQ-028 de = 1 iff x_loc < H_RES and y_loc < V_RES.
REQ-029 line_start = 1 for exactly the clk after a ce step that set x_loc to 0; frame_start additionally requires y_loc to 0.
REQ-030 No other state; counters never exceed H_TOTAL-1 / V_TOTAL-1.

Reset
REQ-031 rst=1 at clk SHALL set x_loc=H_TOTAL-1, y_loc=V_TOTAL-1, h_sync=~H_POL, v_sync=~V_POL, de=0, line_start=0, frame_start=0, regardless of ce.
REQ-032 rst SHALL take priority over ce; asserted mid-frame it SHALL abort the frame in one clk.
REQ-033 First ce=1 clk after rst release SHALL move to (0,0) with de=1, line_start=1, frame_start=1.

Verification (H_RES=4,H_FRONT_PORCH=1,H_SYNC_PULSE=2,H_BACK_PORCH=1,V_RES=3,V_FRONT_PORCH=1,V_SYNC_PULSE=1,V_BACK_PORCH=1, H_POL=0, V_POL=1: H_TOTAL=8, V_TOTAL=6)
REQ-034 rst 2 clks, ce=1 -> during rst x=7,y=5,h_sync=1,v_sync=0,de=0; first clk after -> x=0,y=0,de=1,frame_start=1.
REQ-035 ce=1 continuous for one line -> de=1 for x=0..3, h_sync=0 exactly at x=5,6, line_start once per 8 clks.
REQ-036 ce=1 for 48 clks -> v_sync=1 for 8 clks at y=4, de high 12 clks, frame_start period 48 clks.
REQ-037 ce toggled 1,0,1,0 -> x advances every other clk, line_start/frame_start never wider than 1 clk.
REQ-038 rst at x=2,y=1 with ce=1 -> next clk x=7,y=5,de=0; following ce clk frame_start=1.
